// File: rtl/nibble_stream_tx_pkg.sv
// Shared types for the nibble-serial transmit/receive path.
package nibble_stream_tx_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_DONE
  } NibTxState;

  // Valid/ready nibble channel, for pairing with a future receiver.
  typedef struct packed {
    logic [NIBBLE_W-1:0] data;
    logic                valid;
    logic                last;
  } NibChan;

endpackage

// File: rtl/nibble_stream_tx.sv
// Nibble-serial transmitter: latches a word on an accepted start and emits
// nibbles_number+1 nibbles over a valid/ready channel, LSB- or MSB-first.
module nibble_stream_tx
  import nibble_stream_tx_pkg::*;
#(
  parameter int NIBBLES = 8,
  parameter int IDX_W   = $clog2(NIBBLES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        msb_first,
  input  logic [IDX_W-1:0]            nibbles_number,
  input  logic [NIBBLE_W*NIBBLES-1:0] word,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE_W-1:0]         nib_data,
  output logic                        nib_valid,
  input  logic                        nib_ready,
  output logic                        nib_last
);

  NibTxState                        r_state;
  NibTxState                        w_state_nxt;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] r_word;
  logic                             r_msb;
  logic [IDX_W-1:0]                 r_last_idx;
  logic [IDX_W-1:0]                 r_idx;
  logic [IDX_W-1:0]                 w_final_idx;
  logic                             w_accept;
  logic                             w_beat;
  logic                             w_at_final;

  // The index walks down to 0 when MSB-first, up to the latched count otherwise.
  assign w_final_idx = r_msb ? '0 : r_last_idx;
  assign w_at_final  = (r_idx == w_final_idx);
  assign w_accept    = (r_state == TX_IDLE) && start;
  assign w_beat      = (r_state == TX_SEND) && nib_ready;

  // State register; reset abandons any transfer without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= TX_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic and state-decoded channel outputs.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    nib_valid   = 1'b0;
    nib_last    = 1'b0;
    nib_data    = '0;
    case (r_state)
      TX_IDLE: begin
        if (start) w_state_nxt = TX_SEND;
      end
      TX_SEND: begin
        busy      = 1'b1;
        nib_valid = 1'b1;
        nib_data  = r_word[r_idx];
        nib_last  = w_at_final;
        if (nib_ready && w_at_final) w_state_nxt = TX_DONE;
      end
      TX_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = TX_IDLE;
      end
      default: w_state_nxt = TX_IDLE;
    endcase
  end

  // Capture the operand on accept; step the index on every non-final handshake
  // so it never moves past the final nibble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word     <= '0;
      r_msb      <= 1'b0;
      r_last_idx <= '0;
      r_idx      <= '0;
    end else if (w_accept) begin
      r_word     <= word;
      r_msb      <= msb_first;
      r_last_idx <= nibbles_number;
      r_idx      <= msb_first ? nibbles_number : '0;
    end else if (w_beat && !w_at_final) begin
      r_idx <= r_msb ? (r_idx - IDX_W'(1)) : (r_idx + IDX_W'(1));
    end
  end

endmodule

// File: tb/tb_nibble_stream_tx.sv
// Self-checking bench for nibble_stream_tx: directed vector table, a reset
// corner sequence, and randomized transfers against a beat-order model.
module tb_nibble_stream_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        msb_first;
  logic [2:0]  nibbles_number;
  logic [31:0] word;
  logic        busy;
  logic        done;
  logic [3:0]  nib_data;
  logic        nib_valid;
  logic        nib_ready;
  logic        nib_last;

  int checks = 0;
  int errors = 0;

  nibble_stream_tx #(.NIBBLES(8), .IDX_W(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .msb_first      (msb_first),
    .nibbles_number (nibbles_number),
    .word           (word),
    .busy           (busy),
    .done           (done),
    .nib_data       (nib_data),
    .nib_valid      (nib_valid),
    .nib_ready      (nib_ready),
    .nib_last       (nib_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        msb;
    logic [2:0]  nn;
    logic [31:0] w;
    int          mode;     // 0: ready high, 1: ready toggles 0/1, 2: random
    logic [31:0] exp_seq;  // beat k in bits [4k+3:4k]
    int          exp_cnt;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Beat-ordered sequence: the k-th beat carries nibble k (LSB-first) or nn-k (MSB-first).
  function automatic logic [31:0] ref_seq(input logic m, input int nn, input logic [31:0] w);
    logic [31:0] s;
    int          src;
    s = '0;
    for (int k = 0; k <= nn; k++) begin
      src = m ? (nn - k) : k;
      s = s | (((w >> (4 * src)) & 32'hF) << (4 * k));
    end
    return s;
  endfunction

  task automatic run_tx(input string name, input logic m, input logic [2:0] n,
                        input logic [31:0] w, input int mode,
                        input logic [31:0] exp_seq, input int exp_cnt);
    int          beats, stalls, busy_cyc;
    logic        stalled, finished, pulsed, rdy;
    logic [3:0]  prev_data;
    logic [31:0] exp_nib;
    beats = 0; stalls = 0; busy_cyc = 0;
    stalled = 1'b0; finished = 1'b0; pulsed = 1'b0;
    prev_data = '0;
    @(negedge clk);
    start = 1'b1; msb_first = m; nibbles_number = n; word = w;
    @(negedge clk);
    start = 1'b0; word = $urandom; msb_first = ~m; nibbles_number = ~n;
    chk({name, "_lat_valid"}, {31'b0, nib_valid}, 32'd1);
    chk({name, "_lat_busy"}, {31'b0, busy}, 32'd1);
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      if (cyc > 0) @(negedge clk);
      start = 1'b0;
      if (busy) busy_cyc++;
      if (done) begin
        chk({name, "_beats"}, beats, exp_cnt);
        chk({name, "_done_valid"}, {31'b0, nib_valid}, 32'd0);
        chk({name, "_busy_cycles"}, busy_cyc, beats + stalls + 1);
        finished  = 1'b1;
        nib_ready = 1'b0;
        start     = 1'b1;   // must be ignored while done is high
      end else if (nib_valid) begin
        exp_nib = (exp_seq >> (4 * beats)) & 32'hF;
        chk({name, "_data"}, {28'b0, nib_data}, exp_nib);
        chk({name, "_last"}, {31'b0, nib_last}, {31'b0, (beats == exp_cnt - 1)});
        if (stalled) chk({name, "_stall_stable"}, {28'b0, nib_data}, {28'b0, prev_data});
        prev_data = nib_data;
        if (mode == 0)      rdy = 1'b1;
        else if (mode == 1) rdy = (cyc % 2) == 1;
        else                rdy = ($urandom_range(0, 3) != 0);
        nib_ready = rdy;
        if (rdy) beats++; else stalls++;
        stalled = !rdy;
        if (!pulsed && beats >= 1 && exp_cnt > 1) begin
          start  = 1'b1;
          word   = 32'h1111_1111;
          pulsed = 1'b1;
        end
      end else begin
        chk({name, "_valid_gap"}, {31'b0, nib_valid}, 32'd1);
      end
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
    @(negedge clk);
    start = 1'b0;
    chk({name, "_done_pulse"}, {31'b0, done}, 32'd0);
    chk({name, "_idle_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; msb_first = 1'b0; nibbles_number = '0;
    word = '0; nib_ready = 1'b0;

    vecs[0] = '{"lsb8",   1'b0, 3'd7, 32'h8765_4321, 0, 32'h8765_4321, 8};
    vecs[1] = '{"msb8",   1'b1, 3'd7, 32'h0600_0000, 0, 32'h0000_0060, 8};
    vecs[2] = '{"stall2", 1'b0, 3'd1, 32'hFFFF_00A5, 1, 32'h0000_00A5, 2};
    vecs[3] = '{"one_l",  1'b0, 3'd0, 32'h0000_000C, 0, 32'h0000_000C, 1};
    vecs[4] = '{"one_m",  1'b1, 3'd0, 32'h0000_000C, 0, 32'h0000_000C, 1};

    repeat (2) @(negedge clk);
    chk("rst_busy",  {31'b0, busy},      32'd0);
    chk("rst_done",  {31'b0, done},      32'd0);
    chk("rst_valid", {31'b0, nib_valid}, 32'd0);
    chk("rst_last",  {31'b0, nib_last},  32'd0);
    chk("rst_data",  {28'b0, nib_data},  32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_tx(vecs[i].name, vecs[i].msb, vecs[i].nn, vecs[i].w,
             vecs[i].mode, vecs[i].exp_seq, vecs[i].exp_cnt);

    // Asynchronous reset in the middle of a transfer.
    @(negedge clk);
    start = 1'b1; msb_first = 1'b0; nibbles_number = 3'd7; word = 32'hA1B2_C3D4;
    nib_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, nib_valid}, 32'd0);
    chk("arst_busy",  {31'b0, busy},      32'd0);
    chk("arst_done",  {31'b0, done},      32'd0);
    chk("arst_data",  {28'b0, nib_data},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    nib_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_no_done", {31'b0, done}, 32'd0);
      chk("arst_idle",    {31'b0, busy}, 32'd0);
    end
    run_tx("after_rst", 1'b0, 3'd7, 32'h3C5A_9E7F, 0, 32'h3C5A_9E7F, 8);

    // Randomized transfers against the beat-order model.
    for (int t = 0; t < 40; t++) begin
      logic        m;
      logic [2:0]  n;
      logic [31:0] w;
      m = 1'($urandom_range(0, 1));
      n = 3'($urandom_range(0, 7));
      w = $urandom;
      run_tx($sformatf("rnd%0d", t), m, n, w, 2, ref_seq(m, int'(n), w), int'(n) + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
